// File: rtl/multicycle_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, ALUCtrl encodings and FSM states shared by multicycle_ctrl (optional ILLEGAL_TRAP_EN).
package riscv_ctrl_pkg;
  localparam int OPCODE_W = 7;
  localparam int ALUCTRL_W = 4;
  localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUCTRL_W-1:0] ALU_SRL = 4'b1000;
  localparam logic [ALUCTRL_W-1:0] ALU_SLL = 4'b1001;
  localparam logic [ALUCTRL_W-1:0] ALU_SRA = 4'b1010;
  localparam logic [ALUCTRL_W-1:0] ALU_XOR = 4'b1101;
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory handshake and datapath control bundle; illegal_instr exists only with ILLEGAL_TRAP_EN.
interface multicycle_ctrl_if;
  import riscv_ctrl_pkg::*;
  logic [31:0] instr;
  logic zero;
  logic imem_ready;
  logic dmem_ready;
  logic imem_req;
  logic dmem_req;
  logic MemRead;
  logic MemWrite;
  logic ALUSrc;
  logic [ALUCTRL_W-1:0] ALUCtrl;
  logic MemtoReg;
  logic RegWrite;
  logic loadPC;
  logic PCSrc;
  logic [2:0] state;
  logic retire;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif
  modport master (
    input  instr, zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, MemRead, MemWrite, ALUSrc, ALUCtrl, MemtoReg,
           RegWrite, loadPC, PCSrc, state, retire
`ifdef ILLEGAL_TRAP_EN
    , output illegal_instr
`endif
  );
  modport slave (
    output instr, zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, MemRead, MemWrite, ALUSrc, ALUCtrl, MemtoReg,
           RegWrite, loadPC, PCSrc, state, retire
`ifdef ILLEGAL_TRAP_EN
    , input illegal_instr
`endif
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps opcode, funct3 and funct7[5] to the ALUCtrl encoding.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  output logic [ALUCTRL_W-1:0] alu_ctrl
);
  logic [ALUCTRL_W-1:0] arith;
  always_comb begin
    case (funct3)
      3'b001:  arith = ALU_SLL;
      3'b010:  arith = ALU_SLT;
      3'b100:  arith = ALU_XOR;
      3'b101:  arith = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith = ALU_OR;
      3'b111:  arith = ALU_AND;
      default: arith = ALU_ADD;
    endcase
    // with funct7[5] set, R-type only defines SUB and SRA; everything else falls back to ADD
    alu_ctrl = opcode == OP_BEQ ? ALU_SUB :
               (opcode == OP_I || (opcode == OP_R && !funct7_5)) ? arith :
               (opcode == OP_R && funct3 == 3'b000) ? ALU_SUB :
               (opcode == OP_R && funct3 == 3'b101) ? ALU_SRA : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB control FSM with imem/dmem wait states.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT; otherwise they run as NOPs.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);
  state_t st;
  logic [31:0] ir;
  logic zero_q;
  logic [OPCODE_W-1:0] opc;
  logic [ALUCTRL_W-1:0] alu_ctrl_d;
  logic is_r, is_i, is_lw, is_sw, is_beq;
  logic ir_unused;
  assign opc = ir[OPCODE_W-1:0];
  assign is_r = opc == OP_R;
  assign is_i = opc == OP_I;
  assign is_lw = opc == OP_LW;
  assign is_sw = opc == OP_SW;
  assign is_beq = opc == OP_BEQ;
  assign ir_unused = ^{ir[31], ir[29:15], ir[11:7]};
  assign bus.state = st;
  alu_decoder u_dec (
    .opcode  (opc),
    .funct3  (ir[14:12]),
    .funct7_5(ir[30]),
    .alu_ctrl(alu_ctrl_d)
  );
  // strobes default low every cycle; each state re-asserts only what it owns
  always_ff @(posedge clk) begin
    bus.imem_req <= 1'b0;
    bus.dmem_req <= 1'b0;
    bus.MemRead <= 1'b0;
    bus.MemWrite <= 1'b0;
    bus.RegWrite <= 1'b0;
    bus.loadPC <= 1'b0;
    bus.PCSrc <= 1'b0;
    bus.retire <= 1'b0;
    if (!rst) begin
      st <= S_IF;
      ir <= '0;
      zero_q <= 1'b0;
      bus.ALUSrc <= 1'b0;
      bus.ALUCtrl <= '0;
      bus.MemtoReg <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      bus.illegal_instr <= 1'b0;
`endif
    end else begin
      case (st)
        S_IF:
          if (bus.imem_req && bus.imem_ready) begin
            ir <= bus.instr;
            st <= S_ID;
          end else bus.imem_req <= 1'b1;
        S_ID:
`ifdef ILLEGAL_TRAP_EN
          if (!is_legal(opc)) begin
            st <= S_HALT;
            bus.illegal_instr <= 1'b1;
          end else
`endif
          begin
            st <= S_EX;
            bus.ALUSrc <= is_i | is_lw | is_sw;
            bus.ALUCtrl <= alu_ctrl_d;
            bus.MemtoReg <= is_lw;
          end
        S_EX: begin
          zero_q <= bus.zero;
          st <= S_MEM;
          bus.dmem_req <= is_lw | is_sw;
          bus.MemRead <= is_lw;
          bus.MemWrite <= is_sw;
        end
        S_MEM:
          if (bus.dmem_req && !bus.dmem_ready) begin
            bus.dmem_req <= 1'b1;
            bus.MemRead <= bus.MemRead;
            bus.MemWrite <= bus.MemWrite;
          end else begin
            st <= S_WB;
            bus.loadPC <= 1'b1;
            bus.retire <= 1'b1;
            bus.RegWrite <= is_r | is_i | is_lw;
            bus.PCSrc <= is_beq & zero_q;
          end
        S_WB: begin
          st <= S_IF;
          bus.imem_req <= 1'b1;
          bus.ALUSrc <= 1'b0;
          bus.ALUCtrl <= '0;
          bus.MemtoReg <= 1'b0;
        end
        S_HALT: st <= S_HALT;
        default: st <= S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus randomized instructions checked per cycle against a phase-table model.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  logic [3:0] base_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_ADD, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  logic [3:0] alt_tab [8] = '{ALU_SUB, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_SRA, ALU_ADD, ALU_ADD};
  logic [6:0] op_tab [5] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] obs();
    return {bus.state, bus.imem_req, bus.dmem_req, bus.MemRead, bus.MemWrite, bus.ALUSrc,
            bus.ALUCtrl, bus.MemtoReg, bus.RegWrite, bus.loadPC, bus.PCSrc, bus.retire};
  endfunction

  function automatic logic [3:0] alu_ref(input logic [31:0] ins);
    logic [2:0] f3 = ins[14:12];
    case (ins[6:0])
      OP_BEQ: return ALU_SUB;
      OP_R:   return ins[30] ? alt_tab[f3] : base_tab[f3];
      OP_I:   return (f3 == 3'b101 && ins[30]) ? ALU_SRA : base_tab[f3];
      default: return ALU_ADD;
    endcase
  endfunction

  // ph: 0=IF 1=ID 2=EX 3=MEM 4=WB
  function automatic logic [16:0] exp_vec(input int ph, input logic [31:0] ins, input logic z);
    logic [6:0] op = ins[6:0];
    logic lw = op == OP_LW;
    logic sw = op == OP_SW;
    logic dec = ph >= 2;
    logic mem = ph == 3;
    logic wb = ph == 4;
    return {3'(ph), ph == 0, mem && (lw || sw), mem && lw, mem && sw,
            dec && (op == OP_I || lw || sw), dec ? alu_ref(ins) : 4'b0, dec && lw,
            wb && (op == OP_R || op == OP_I || lw), wb, wb && op == OP_BEQ && z, wb};
  endfunction

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] ins = $urandom;
    logic [6:0] op;
    if (kind < 5) op = op_tab[kind];
    else begin
      op = 7'($urandom);
      while (is_legal(op)) op = 7'($urandom);
    end
    ins[6:0] = op;
    return ins;
  endfunction

  task automatic run(input logic [31:0] ins, input int iw, input int dw, input logic z, input bit kill);
    logic [6:0] op = ins[6:0];
    bit memop = op == OP_LW || op == OP_SW;
    int nmem = memop ? dw + 1 : 1;
    for (int c = 0; c < iw + nmem + 4; c++) begin
      int ph;
      int m;
      ph = c <= iw ? 0 : c == iw + 1 ? 1 : c == iw + 2 ? 2 : c < iw + 3 + nmem ? 3 : 4;
      m = c - iw - 3;
      check($sformatf("%h_c%0d_ph%0d", ins, c, ph), 32'(obs()), 32'(exp_vec(ph, ins, z)));
      bus.imem_ready = ph == 0 ? c == iw : 1'($urandom);
      bus.instr = (ph == 0 && c == iw) ? ins : $urandom;
      bus.dmem_ready = (ph == 3 && memop) ? m == dw : 1'($urandom);
      bus.zero = ph == 2 ? z : 1'($urandom);
      if (kill && ph == 3 && m == 1) begin
        rst = 1'b0;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        check("rst_in_mem", 32'(obs()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.instr = '0;
    bus.zero = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    check("reset0", 32'(obs()), 32'd0);
    @(negedge clk);
    check("reset1", 32'(obs()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset", 32'(obs()), 32'(exp_vec(0, 32'd0, 1'b0)));
    run(32'h002081B3, 0, 0, 1'b0, 1'b0);
    run(32'h0080A283, 0, 2, 1'b0, 1'b0);
    run(32'h00208463, 0, 0, 1'b1, 1'b0);
    run(32'h00208463, 1, 0, 1'b0, 1'b0);
    run(32'h0020A423, 0, 3, 1'b0, 1'b1);
    run(32'h4020D1B3, 2, 0, 1'b0, 1'b0);
    run(32'h4050D093, 0, 0, 1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 40; i++)
      run(rand_instr($urandom_range(0, 4)), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
    bus.imem_ready = 1'b1;
    bus.instr = 32'h0000007F;
    @(negedge clk);
    check("halt_id", 32'(obs()), 32'(exp_vec(1, 32'h7F, 1'b0)));
    for (int i = 0; i < 4; i++) begin
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      @(negedge clk);
      check("halt_state", 32'(obs()), {15'd0, 3'd5, 14'd0});
      check("halt_illegal", 32'(bus.illegal_instr), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk);
    check("halt_reset", 32'({bus.illegal_instr, obs()}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
`else
    run(32'h0000007F, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)
      run(rand_instr($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the 32-bit RISC-V datapath through the fixed phases IF, ID, EX, MEM and WB.
- Generates the datapath control signals: ALUSrc, ALUCtrl, MemtoReg, RegWrite, loadPC and PCSrc.
- Handshakes with instruction memory and data memory so that both may insert wait states.
- Supports R-type ALU ops, I-type ALU ops, LW, SW and BEQ.

Parameters:
- OPCODE_W, 7, opcode field width.
- ALUCTRL_W, 4, width of the ALUCtrl bus.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 sampled at the rising edge resets the block).
- instr  in  32  instruction word from instruction memory; sampled only when imem_ready=1 in IF.
- zero  in  1  ALU zero flag from the datapath.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data access request.
- MemRead  out  1  load strobe.
- MemWrite  out  1  store strobe.
- ALUSrc  out  1  selects the immediate as ALU operand 2.
- ALUCtrl  out  4  ALU operation select.
- MemtoReg  out  1  selects memory read data for writeback.
- RegWrite  out  1  register file write enable.
- loadPC  out  1  PC update strobe.
- PCSrc  out  1  1 = PC+branch offset, 0 = PC+4.
- state  out  3  current FSM state, for debug.
- retire  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5 (HALT exists only with the optional feature).
- Reset: state=IF; ir=0; zero_q=0; every output 0.
- Reset applies from any state, including MEM with dmem_req high. The next cycle is IF with all strobes low. No partial write is issued after reset.

State transitions:
- IF: imem_req=1. Stays in IF while imem_ready=0. When imem_ready=1, ir<=instr and next state is ID. Minimum one cycle.
- ID: decodes ir; always lasts one cycle; next state EX.
- EX: zero_q<=zero at the end of EX; next state MEM.
- MEM, LW/SW: dmem_req=1. LW also drives MemRead=1; SW also drives MemWrite=1. Stays in MEM until dmem_ready=1, then goes to WB.
- MEM, other opcodes: no request is issued; lasts one cycle.
- WB: loadPC=1 and retire=1 for exactly one cycle; RegWrite=1 for R/I/LW only; next state IF.

Control decode:
- ALUSrc, ALUCtrl and MemtoReg are decoded from ir. They are held stable from EX through WB and are 0 in IF.
- ALUSrc=1 for I-type, LW and SW.
- MemtoReg=1 for LW only.
- PCSrc = (opcode==BEQ) & zero_q. It is valid in WB; 0 otherwise.
- ALUCtrl for LW/SW = ADD; for BEQ = SUB.
- R-type ALUCtrl from {funct7[5],funct3}: ADD/SUB, SLL, SLT, XOR, SRL/SRA, OR, AND.
- I-type ALUCtrl from funct3; funct7[5] is used only for SRAI.
- Unsupported funct combinations within a supported opcode decode as ADD.

Boundary conditions:
- imem_ready or dmem_ready asserted outside the state that waits on it: ignored.
- dmem_ready=1 on the first MEM cycle: MEM lasts exactly one cycle.
- Minimum latency per instruction: 5 cycles. Waits are unbounded; the block has no timeout.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- With the macro defined:
  - An opcode outside {0110011, 0010011, 0000011, 0100011, 1100011} moves ID to HALT.
  - HALT asserts an extra output illegal_instr=1 and drives all strobes to 0.
  - The FSM stays in HALT until reset.
- Without the macro: an unknown opcode executes as a NOP. It passes through all five states with RegWrite=0 and no memory request, and WB performs PC+4 (loadPC=1, PCSrc=0).

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the opcode localparams: OP_R, OP_I, OP_LW, OP_SW, OP_BEQ;
  - the ALUCtrl encodings: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101;
  - the state encodings.
- One combinational sub-module, alu_decoder, maps (opcode, funct3, funct7[5]) to ALUCtrl. The FSM, ir and zero_q stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release. Required: state=IF and imem_req=1; all other outputs 0.
- ADD x3,x1,x2 (0x002081B3) with zero-wait memories. Required: WB on cycle 5 with RegWrite=1, ALUCtrl=0010, ALUSrc=0, loadPC=1, PCSrc=0, retire=1.
- LW x5,8(x1) (0x0080A283) with dmem_ready delayed 3 cycles. Required: MemRead and dmem_req held 3 cycles; MemtoReg=1, ALUSrc=1; WB on cycle 7.
- BEQ (0x00208463):
  - zero=1 in EX: WB has PCSrc=1, loadPC=1, RegWrite=0.
  - zero=0 in EX: PCSrc=0.
- SW (0x0020A423) with rst driven 0 during the MEM wait. Required: MemWrite drops at the next edge, state=IF, and retire is never pulsed.
- Opcode 0x0000007F:
  - with ILLEGAL_TRAP_EN: state=HALT and illegal_instr=1 from the cycle after ID.
  - without it: retire=1 at WB with RegWrite=0, loadPC=1, PCSrc=0.
